secuenciador_mac: RTL and testbench
===================================

# secuenciador_mac

Coefficient reader and multiply-accumulate engine for the servo control path. On each new sample it drives the 4-bit coefficient index `estados` into the combinational coefficient ROM and reads back the signed `Constantes`. It forms y = Σ C[k]·x[n−k] over `n_taps` taps in fixed point, then shifts, saturates and registers the result for the servo output stage.

## Interface
- `cant_bits`, 16, sample/coefficient/result width (signed, two's complement).
- `frac_bits`, 8, fractional bits of coefficients; product sum is shifted right by this amount.
- `n_taps`, 7, number of taps and ROM indices used (0..n_taps−1); legal range 1..16.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request: new sample on `x_in`; ignored while `busy`=1.
- `x_in`  in  cant_bits  signed new sample, sampled on the edge that accepts `start`.
- `Constantes`  in  cant_bits  signed coefficient returned combinationally by the ROM for current `estados`.
- `estados`  out  4  coefficient ROM index.
- `y_out`  out  cant_bits  signed filtered result, held until next result.
- `done`  out  1  one-cycle pulse, `y_out`/`sat` updated.
- `busy`  out  1  high from acceptance of `start` until `done`.
- `sat`  out  1  result was clamped; valid with `done`, held with `y_out`.

## Operation
- States: IDLE, MAC, OUT.
- IDLE: `estados`=0, `busy`=0. On `start`=1:
  - shift sample history (x[0]←`x_in`, x[k]←x[k−1]);
  - clear accumulator and tap counter;
  - go to MAC.
- MAC: `estados`=tap counter k. Each cycle:
  - acc += `Constantes`·x[k] (full-width signed product, acc width 2·cant_bits+4);
  - k increments.
  - After the cycle with k=n_taps−1, go to OUT.
- OUT: r = acc >>> frac_bits (arithmetic shift). r is clamped to [−2^(cant_bits−1), 2^(cant_bits−1)−1].
  - `y_out`←clamped r; `sat`←(clamp applied).
  - `done` is registered high for the following cycle.
  - Return to IDLE.
- `start` while `busy`=1: ignored, no history shift.
- `start` in the cycle `done` is high: accepted (`busy` is already 0).
- Reset (any time, including mid-MAC): asynchronous. State=IDLE, history=0, acc=0, `estados`=0, `y_out`=0, `done`=0, `busy`=0, `sat`=0. A partial computation is discarded and never produces `done`.

## Timing
- Edge E0 accepts `start`. Cycles after E0 carry `estados`=0..n_taps−1, one per cycle.
- Edge E0+n_taps moves to OUT. Edge E0+n_taps+1 registers `y_out`, `sat`, `done`.
- `done` is high in the cycle after edge E0+n_taps+1. With defaults: 8 edges after acceptance, for 1 cycle.
- `busy` is high from after E0 until `done` rises. Max sample rate is one per n_taps+2 cycles.
- ROM path: `estados` (registered) → `Constantes` → multiplier → acc is a single-cycle combinational path.

## Configuration
- `SECUENCIADOR_MAC_ROUND_EN` defined: 2^(frac_bits−1) is added to acc before the shift (round half up).
- Not defined: plain arithmetic-shift truncation (toward −∞).
- Saturation is identical in both builds.

## Test plan
Coefficients in the ROM: 0x6400, 0x6400, 0x4B00, 0x2800, 0x2D00, 0x3200, 0x7FFF.

- Impulse: after reset, `x_in`=0x0100, then six samples of 0x0000, each on `start` after `done`. Expect `y_out` = 0x6400, 0x6400, 0x4B00, 0x2800, 0x2D00, 0x3200, 0x7FFF; `sat`=0. An 8th zero sample gives 0x0000. Each `done` arrives exactly 8 edges after acceptance, and `estados` steps 0..6.
- Rounding: `x_in`=0x0001, then six zeros. 7th result = 0x007F without the macro, 0x0080 with `SECUENCIADOR_MAC_ROUND_EN`.
- Saturation: seven samples of 0x7FFF → 7th `y_out`=0x7FFF, `sat`=1. Then seven samples of 0x8000 → `y_out`=0x8000, `sat`=1.
- Busy protocol: assert `start` (`x_in`=0x0100) then `start` again at edge E0+3 with `x_in`=0x1234. Only one `done`, `y_out`=0x6400; the next impulse-response value proves 0x1234 was not shifted in.
- Reset mid-operation: pull `reset_n` low during MAC (`estados`=3). All outputs go to 0 immediately, no `done` follows. A fresh impulse gives 0x6400 first (history cleared).
- Back-to-back: assert `start` in the cycle `done` is high → accepted, second `done` 8 edges later.

Source files
------------

// File: rtl/secuenciador_mac.sv
// Coefficient reader and multiply-accumulate engine for the servo path: y = sum C[k]*x[n-k],
// shifted, saturated and registered. Define SECUENCIADOR_MAC_ROUND_EN for round-half-up before the shift.
module secuenciador_mac #(
    parameter int cant_bits = 16,
    parameter int frac_bits = 8,
    parameter int n_taps    = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [cant_bits-1:0] x_in,
    input  logic [cant_bits-1:0] Constantes,
    output logic [3:0]           estados,
    output logic [cant_bits-1:0] y_out,
    output logic                 done,
    output logic                 busy,
    output logic                 sat
);

    localparam int AW = 2 * cant_bits + 4;
    localparam logic [3:0] LAST_TAP = 4'(n_taps - 1);
    localparam logic signed [AW-1:0] Y_MAX = {{(AW-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN = {{(AW-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                      state_q;
    logic signed [cant_bits-1:0] hist_q [n_taps];
    logic signed [AW-1:0]        acc_q;
    logic [3:0]                  k_q;
    logic [cant_bits-1:0]        y_q;
    logic                        done_q;
    logic                        busy_q;
    logic                        sat_q;

    logic signed [cant_bits-1:0]   x_sel_d;
    logic signed [2*cant_bits-1:0] prod_d;
    logic signed [AW-1:0]          acc_sum_d;
    logic signed [AW-1:0]          acc_adj_d;
    logic signed [AW-1:0]          shifted_d;
    logic [cant_bits-1:0]          y_d;
    logic                          sat_d;

    // Tap counter doubles as the ROM index; it rests at 0 outside MAC.
    assign estados = k_q;
    assign y_out   = y_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign sat     = sat_q;

    always_comb begin
        x_sel_d = '0;
        for (int i = 0; i < n_taps; i++) begin
            if (k_q == i[3:0]) begin
                x_sel_d = hist_q[i];
            end
        end
    end

    // Registered index -> external ROM -> multiplier -> accumulator in one cycle.
    assign prod_d    = $signed(Constantes) * x_sel_d;
    assign acc_sum_d = acc_q + {{(AW-2*cant_bits){prod_d[2*cant_bits-1]}}, prod_d};

`ifdef SECUENCIADOR_MAC_ROUND_EN
    localparam logic signed [AW-1:0] ROUND_K = AW'(1) << (frac_bits - 1);
    assign acc_adj_d = acc_q + ROUND_K;
`else
    assign acc_adj_d = acc_q;
`endif

    assign shifted_d = acc_adj_d >>> frac_bits;

    always_comb begin
        y_d   = shifted_d[cant_bits-1:0];
        sat_d = 1'b0;
        if (shifted_d > Y_MAX) begin
            y_d   = Y_MAX[cant_bits-1:0];
            sat_d = 1'b1;
        end else if (shifted_d < Y_MIN) begin
            y_d   = Y_MIN[cant_bits-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int i = 0; i < n_taps; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        hist_q[0] <= $signed(x_in);
                        for (int i = 1; i < n_taps; i++) begin
                            hist_q[i] <= hist_q[i-1];
                        end
                        acc_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_sum_d;
                    if (k_q == LAST_TAP) begin
                        k_q     <= '0;
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                OUT: begin
                    y_q     <= y_d;
                    sat_q   <= sat_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_mac.sv
// Scoreboard bench for secuenciador_mac: a fixed-point model predicts each result when a sample is accepted.
module tb_secuenciador_mac;

    localparam int N_TAPS = 7;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] Constantes;
    logic [3:0]  estados;
    logic [15:0] y_out;
    logic        done;
    logic        busy;
    logic        sat;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] mh [N_TAPS];
    logic [15:0] exp_y [$];
    logic        exp_s [$];
    logic [15:0] ey;
    logic        es;

    secuenciador_mac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .x_in      (x_in),
        .Constantes(Constantes),
        .estados   (estados),
        .y_out     (y_out),
        .done      (done),
        .busy      (busy),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_val(input int k);
        case (k)
            0: return 16'h6400;
            1: return 16'h6400;
            2: return 16'h4B00;
            3: return 16'h2800;
            4: return 16'h2D00;
            5: return 16'h3200;
            6: return 16'h7FFF;
            default: return 16'h0000;
        endcase
    endfunction

    assign Constantes = rom_val(int'(estados));

    // Scoreboard: every done pops one prediction.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            checks++;
            if (exp_y.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: y_out=%h sat=%b, required no done", y_out, sat);
            end else begin
                ey = exp_y.pop_front();
                es = exp_s.pop_front();
                if (y_out !== ey || sat !== es) begin
                    errors++;
                    $display("FAIL scoreboard: y_out=%h sat=%b, required y_out=%h sat=%b", y_out, sat, ey, es);
                end else begin
                    $display("txn: y_out=%h sat=%b", y_out, sat);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N_TAPS; i++) mh[i] = '0;
        exp_y.delete();
        exp_s.delete();
    endtask

    task automatic model_push(input logic [15:0] x);
        longint acc;
        longint r;
        logic [15:0] y;
        logic s;
        for (int i = N_TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = x;
        acc = 0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc += longint'($signed(rom_val(k))) * longint'(mh[k]);
        end
`ifdef SECUENCIADOR_MAC_ROUND_EN
        acc += 128;
`endif
        r = acc >>> 8;
        if (r > 32767) begin
            y = 16'h7FFF; s = 1'b1;
        end else if (r < -32768) begin
            y = 16'h8000; s = 1'b1;
        end else begin
            y = r[15:0]; s = 1'b0;
        end
        exp_y.push_back(y);
        exp_s.push_back(s);
    endtask

    // Drive start now; it is accepted on the next rising edge. Returns at E0 + 1.
    task automatic issue(input logic [15:0] x);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_push(x);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b, required 1", busy);
        end
    endtask

    task automatic wait_done(input int start_cnt, input bit chk_est);
        int n;
        bit seen;
        n = start_cnt;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (chk_est && n < N_TAPS) begin
                checks++;
                if (estados !== 4'(n)) begin
                    errors++;
                    $display("FAIL estados_step: estados=%0d, required %0d", estados, n);
                end
            end
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != N_TAPS + 1) begin
            errors++;
            $display("FAIL done_latency: seen=%b edges=%0d, required edges=%0d", seen, n, N_TAPS + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (y_out !== 16'h0 || done !== 1'b0 || busy !== 1'b0 || sat !== 1'b0 || estados !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: y=%h done=%b busy=%b sat=%b est=%h, required all 0",
                     y_out, done, busy, sat, estados);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_impulse();
        logic [15:0] xs   [8] = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] want [8] = '{16'h6400, 16'h6400, 16'h4B00, 16'h2800,
                                  16'h2D00, 16'h3200, 16'h7FFF, 16'h0000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(xs[i]);
            wait_done(0, 1'b1);
            checks++;
            if (y_out !== want[i] || sat !== 1'b0) begin
                errors++;
                $display("FAIL impulse[%0d]: y_out=%h sat=%b, required %h sat=0", i, y_out, sat, want[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width: done=%b busy=%b, required 0 0", done, busy);
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] want;
`ifdef SECUENCIADOR_MAC_ROUND_EN
        want = 16'h0080;
`else
        want = 16'h007F;
`endif
        do_reset();
        for (int i = 0; i < N_TAPS; i++) begin
            @(negedge clk);
            issue((i == 0) ? 16'h0001 : 16'h0000);
            wait_done(0, 1'b0);
        end
        checks++;
        if (y_out !== want || sat !== 1'b0) begin
            errors++;
            $display("FAIL rounding: y_out=%h sat=%b, required %h sat=0", y_out, sat, want);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < N_TAPS; i++) begin
            @(negedge clk);
            issue(16'h7FFF);
            wait_done(0, 1'b0);
        end
        checks++;
        if (y_out !== 16'h7FFF || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: y_out=%h sat=%b, required 7fff sat=1", y_out, sat);
        end
        for (int i = 0; i < N_TAPS; i++) begin
            @(negedge clk);
            issue(16'h8000);
            wait_done(0, 1'b0);
        end
        checks++;
        if (y_out !== 16'h8000 || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: y_out=%h sat=%b, required 8000 sat=1", y_out, sat);
        end
    endtask

    task automatic test_busy_protocol();
        do_reset();
        @(negedge clk);
        issue(16'h0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        x_in  = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: busy=%b, required 1", busy);
        end
        wait_done(3, 1'b0);
        checks++;
        if (y_out !== 16'h6400) begin
            errors++;
            $display("FAIL busy_first: y_out=%h, required 6400", y_out);
        end
        @(negedge clk);
        issue(16'h0000);
        wait_done(0, 1'b0);
        checks++;
        if (y_out !== 16'h6400) begin
            errors++;
            $display("FAIL busy_no_shift: y_out=%h, required 6400", y_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int dones;
        do_reset();
        @(negedge clk);
        issue(16'h0100);
        wait_done(0, 1'b0);
        @(negedge clk);
        issue(16'h0100);
        n = 0;
        while (estados !== 4'd3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (estados !== 4'd3) begin
            errors++;
            $display("FAIL reach_tap3: estados=%0d, required 3", estados);
        end
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (y_out !== 16'h0 || done !== 1'b0 || busy !== 1'b0 || sat !== 1'b0 || estados !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: y=%h done=%b busy=%b sat=%b est=%h, required all 0",
                     y_out, done, busy, sat, estados);
        end
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: dones=%0d, required 0", dones);
        end
        @(negedge clk);
        issue(16'h0100);
        wait_done(0, 1'b0);
        checks++;
        if (y_out !== 16'h6400) begin
            errors++;
            $display("FAIL fresh_impulse: y_out=%h, required 6400", y_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        issue(16'h0100);
        wait_done(0, 1'b0);
        issue(16'h0000);
        wait_done(0, 1'b0);
        checks++;
        if (y_out !== 16'h6400) begin
            errors++;
            $display("FAIL back_to_back: y_out=%h, required 6400", y_out);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_busy_protocol();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_y.size() != 0) begin
            errors++;
            $display("FAIL missing_done: pending=%0d, required 0", exp_y.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
